mant_mult_seq: RTL and testbench
================================

Name: mant_mult_seq

Overview:
Iterative shift-and-add mantissa multiplier: the producer end of the mantissa datapath in the real multiplier. It takes two MANT_W-bit significands with the hidden bit included and computes their 2*MANT_W-bit product. It normalises the product by at most one position, so the MSB of the result is in bit 2*MANT_W-1, and reports the exponent adjustment. Its output feeds the mantissa rounding stage directly.

Parameters:
MANT_W, 24, significand width including hidden bit; product width is 2*MANT_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands a, b, sign_a, sign_b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  MANT_W  multiplicand significand
b  input  MANT_W  multiplier significand
sign_a  input  1  sign of operand a
sign_b  input  1  sign of operand b
out_valid  output  1  product, exp_inc and sign valid
out_ready  input  1  downstream accepts result
product  output  2*MANT_W  normalised product, feeds rounder input
exp_inc  output  1  1 = raw product MSB was set (exponent +1); 0 = product was shifted left by 1
sign  output  1  sign_a XOR sign_b

Behaviour:
- Clock and reset
  - Single clock domain.
  - rst_n low asynchronously forces state IDLE, counter 0, and all internal registers 0.
  - Outputs under reset: in_ready=1, out_valid=0, product=0, exp_inc=0, sign=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready=1.
  - An input handshake (in_valid & in_ready at an edge) does all of the following:
    - latches a into the multiplicand register, zero-extended to 2*MANT_W;
    - latches b into the multiplier shift register;
    - latches sign_a^sign_b;
    - clears the accumulator;
    - loads counter = MANT_W-1;
    - moves to BUSY.
- BUSY
  - in_ready=0; in_valid is ignored.
  - Each cycle:
    - if multiplier LSB is 1: acc += multiplicand;
    - multiplicand <<= 1;
    - multiplier >>= 1;
    - counter decrements.
  - On the edge where counter==0 (MANT_W-th iteration), the final sum is normalised and registered into product/exp_inc, and the state moves to DONE.
  - Latency: out_valid rises exactly MANT_W clock edges after the accept edge.
- Normalisation rule (raw = full 2*MANT_W sum)
  - raw[2*MANT_W-1]=1: product=raw, exp_inc=1.
  - Otherwise: product=raw<<1 (LSB filled 0), exp_inc=0.
  - Only one shift position is applied. Zero or denormal inputs are not normalised further; zero produces product=0, exp_inc=0.
  - No bits are discarded: the accumulator is 2*MANT_W wide and cannot overflow.
- DONE
  - out_valid=1.
  - product, exp_inc and sign are held stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready: go to IDLE next cycle and clear out_valid.
  - product, exp_inc and sign retain their last value after the handshake.
  - No new operand is accepted in the handshake cycle; in_ready rises the cycle after.
- Throughput: one operation per MANT_W+2 cycles minimum, given back-to-back in_valid and out_ready held high.
- Reset mid-operation (BUSY or DONE): immediate return to IDLE; the pending result is lost and no out_valid is produced.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. MANT_W=24, accept a=b=0x800000 (1.0*1.0) -> out_valid exactly 24 edges after accept; raw 0x400000000000 -> product=0x800000000000, exp_inc=0.
2. a=b=0xC00000 (1.5*1.5) with sign_a=1, sign_b=0 -> product=0x900000000000, exp_inc=1, sign=1.
3. a=b=0xFFFFFF -> product=0xFFFFFE000001, exp_inc=1.
4. a=0, b=0xABCDEF -> product=0, exp_inc=0.
5. Backpressure and busy inputs:
   - out_ready held low for 5 cycles after out_valid -> product stays constant, in_ready=0 throughout.
   - in_valid pulsed with new operands during BUSY -> ignored; the result matches the first operands.
6. Assert rst_n=0 in BUSY at iteration 10 -> in_ready=1, out_valid=0, product=0 immediately. After release, a new op a=0x800000, b=0xC00000 -> product=0xC00000000000, exp_inc=0.

Source files
------------

// File: rtl/mant_mult_seq.sv
// mant_mult_seq
// Iterative shift-and-add significand multiplier. It takes two MANT_W-bit
// significands (hidden bit included), forms their 2*MANT_W-bit product over
// MANT_W BUSY cycles, and normalises the product by at most one position so
// that the MSB lands in bit 2*MANT_W-1. It also reports the exponent
// adjustment. The result feeds the mantissa rounding stage directly.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, sign_a, sign_b valid
//   in_ready   operands can be accepted (high only while idle)
//   a, b       multiplicand / multiplier significands, MANT_W bits
//   sign_a/b   operand signs
//   out_valid  product, exp_inc and sign valid
//   out_ready  downstream accepts the result
//   product    normalised 2*MANT_W-bit product
//   exp_inc    1: raw MSB was set (exponent +1); 0: product shifted left by 1
//   sign       sign_a ^ sign_b of the operation that produced product
module mant_mult_seq #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  input  logic                  sign_a,
  input  logic                  sign_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   product,
  output logic                  exp_inc,
  output logic                  sign
);

  localparam int PW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MANT_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [PW-1:0]     mcand_r;
  logic [MANT_W-1:0] mplier_r;
  logic [PW-1:0]     acc_r;
  logic [CW-1:0]     cnt_r;
  logic              sign_lat_r;
  logic [PW-1:0]     product_r;
  logic              exp_inc_r;
  logic              sign_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [PW-1:0]     sum_s;
  logic [PW:0]       norm_s;

  // Single-step normalisation: {exp_inc, product}. A zero or denormal sum is
  // only shifted once, so zero stays zero with exp_inc=0.
  function automatic logic [PW:0] normalise(input logic [PW-1:0] raw);
    logic [PW:0] res;
    if (raw[PW-1]) begin
      res = {1'b1, raw};
    end else begin
      res = {1'b0, raw[PW-2:0], 1'b0};
    end
    return res;
  endfunction

  // Partial-product sum for this iteration and its normalised form.
  always_comb begin
    sum_s = acc_r;
    if (mplier_r[0]) begin
      sum_s = acc_r + mcand_r;
    end else begin
      sum_s = acc_r;
    end
    norm_s = normalise(sum_s);
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {MANT_W{1'b0}};
      acc_r       <= {PW{1'b0}};
      cnt_r       <= CNT_ZERO;
      sign_lat_r  <= 1'b0;
      product_r   <= {PW{1'b0}};
      exp_inc_r   <= 1'b0;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_r    <= {{MANT_W{1'b0}}, a};
            mplier_r   <= b;
            sign_lat_r <= sign_a ^ sign_b;
            acc_r      <= {PW{1'b0}};
            cnt_r      <= CNT_LAST;
          end
        end
        ST_BUSY: begin
          acc_r    <= sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (cnt_r == CNT_ZERO) begin
            // Last iteration: publish the result; the sign moves to the
            // output only now so a held result never changes under it.
            {exp_inc_r, product_r} <= norm_s;
            sign_r                 <= sign_lat_r;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          // Result registers hold until the next operation completes.
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign exp_inc   = exp_inc_r;
  assign sign      = sign_r;

endmodule

// File: tb/tb_mant_mult_seq.sv
// Testbench for mant_mult_seq (MANT_W=24). Directed operand vectors with
// hand-computed results, plus a monitor that checks handshake timing and
// results every cycle against an arithmetic model of the multiplier.
module tb_mant_mult_seq;

  localparam int W  = 24;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sign_a;
  logic          sign_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          exp_inc;
  logic          sign;

  int total = 0;
  int bad   = 0;

  mant_mult_seq #(.MANT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .exp_inc   (exp_inc),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic model: full product by multiplication, then one-step normalise.
  // Returned as {sign, exp_inc, product}.
  function automatic logic [PW+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic sa, input logic sb);
    logic [PW-1:0] raw;
    raw = PW'(ma) * PW'(mb);
    if (raw >= (PW'(1) << (PW - 1))) return {sa ^ sb, 1'b1, raw};
    else return {sa ^ sb, 1'b0, raw * PW'(2)};
  endfunction

  // Monitor state: expected results, outstanding-op flag, edges since accept.
  logic [PW+1:0] exp_q[$];
  logic [PW+1:0] last_res;
  logic [PW+1:0] head;
  bit            held;
  int            age;

  // Per-cycle compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held     = 1'b0;
      age      = 0;
      last_res = '0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_product", 64'(product), 64'd0);
      chk("rst_exp_inc", 64'(exp_inc), 64'd0);
      chk("rst_sign", 64'(sign), 64'd0);
    end else begin
      if (held) age++;
      chk("mon_in_ready", 64'(in_ready), 64'(!held));
      chk("mon_out_valid", 64'(out_valid), 64'(held && (age >= W + 1)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_spurious_valid", 64'd1, 64'd0);
        end else begin
          head = exp_q[0];
          chk("mon_product", 64'(product), 64'(head[PW-1:0]));
          chk("mon_exp_inc", 64'(exp_inc), 64'(head[PW]));
          chk("mon_sign", 64'(sign), 64'(head[PW+1]));
          if (out_ready) begin
            last_res = exp_q.pop_front();
            held     = 1'b0;
          end
        end
      end else begin
        chk("mon_retained_product", 64'(product), 64'(last_res[PW-1:0]));
        chk("mon_retained_exp_inc", 64'(exp_inc), 64'(last_res[PW]));
        chk("mon_retained_sign", 64'(sign), 64'(last_res[PW+1]));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sign_a, sign_b));
        held = 1'b1;
        age  = 0;
      end
    end
  end

  // One operation: accept, measure latency, optional literal checks,
  // optional backpressure and a busy-time in_valid pulse, then handshake.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isa, input logic isb, input int hold,
                        input bit pulse, input bit lit, input logic [PW-1:0] lp,
                        input logic li, input logic ls);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    a = ia; b = ib; sign_a = isa; sign_b = isb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (pulse && n == 5) begin
        in_valid = 1'b1; a = 24'h123456; b = 24'h654321; sign_a = 1'b0; sign_b = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(n), 64'd24);
    if (lit) begin
      chk("lit_product", 64'(product), 64'(lp));
      chk("lit_exp_inc", 64'(exp_inc), 64'(li));
      chk("lit_sign", 64'(sign), 64'(ls));
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    if (lit) chk("hold_product", 64'(product), 64'(lp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid_clear", 64'(out_valid), 64'd0);
    chk("hs_in_ready_set", 64'(in_ready), 64'd1);
    if (lit) chk("hs_product_kept", 64'(product), 64'(lp));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 * 1.0
    run_op(24'h800000, 24'h800000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 48'h800000000000, 1'b0, 1'b0);
    // 1.5 * 1.5, negative
    run_op(24'hC00000, 24'hC00000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 48'h900000000000, 1'b1, 1'b1);
    // all-ones significands
    run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 0, 1'b0, 1'b1, 48'hFFFFFE000001, 1'b1, 1'b0);
    // zero operand
    run_op(24'h000000, 24'hABCDEF, 1'b1, 1'b1, 0, 1'b0, 1'b1, 48'h000000000000, 1'b0, 1'b0);
    // smallest denormal: raw 1 shifted once
    run_op(24'h000001, 24'h000001, 1'b0, 1'b1, 0, 1'b0, 1'b1, 48'h000000000002, 1'b0, 1'b1);
    // backpressure for 5 cycles plus in_valid pulse while busy
    run_op(24'hC00000, 24'hC00000, 1'b0, 1'b1, 5, 1'b1, 1'b1, 48'h900000000000, 1'b1, 1'b1);
    // model-only vectors
    run_op(24'hABCDEF, 24'h123456, 1'b1, 1'b0, 2, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run_op(24'h800001, 24'hFFFFFF, 1'b1, 1'b1, 0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of BUSY
    a = 24'hFFFFFF; b = 24'hFFFFFF; sign_a = 1'b1; sign_b = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_out_valid", 64'(out_valid), 64'd0);
    run_op(24'h800000, 24'hC00000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 48'hC00000000000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
